// File: rtl/hazard_forward_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/forwarding controller:
//   FWD_RF / FWD_MEM / FWD_WB : operand mux select encodings
//   state_t                   : stall sequencer states (RUN, STALL)
//   ZERO_REG                  : index of the hardwired zero register
//   need_t                    : stall cycles a hazard requires (0..2)
// ----------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int unsigned ZERO_REG = 0;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   typedef logic [1:0] need_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_forward_ctrl_if
// Bundles the pipeline-register fields the controller inspects and the
// controls it returns.
//   master : pipeline side (drives stage fields, receives selects/stalls)
//   slave  : hazard_forward_ctrl
// Parameters REG_AW (register address width) and CNT_W (stall counter width)
// must match those of the attached controller.
// ----------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);

   logic              fwd_en;
   logic              mem_ready;
   logic              flush;
   logic [REG_AW-1:0] ID_src1;
   logic [REG_AW-1:0] ID_src2;
   logic              ID_two_src;
   logic [REG_AW-1:0] ID_reg_out_src1;
   logic [REG_AW-1:0] ID_reg_out_src2;
   logic [REG_AW-1:0] ID_reg_out_dest;
   logic              ID_reg_out_WBEN;
   logic              ID_reg_out_MEM_R;
   logic              ID_reg_out_MEM_W;
   logic [REG_AW-1:0] EXE_reg_out_DEST;
   logic              EXE_reg_out_WBEN;
   logic [REG_AW-1:0] MEM_reg_out_DEST;
   logic              MEM_reg_out_WBEN;
   logic [1:0]        forward_a_select;
   logic [1:0]        forward_b_select;
   logic [1:0]        st_val_select;
   logic              hazard_stall;
   logic              mem_freeze;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output fwd_en, mem_ready, flush,
      output ID_src1, ID_src2, ID_two_src,
      output ID_reg_out_src1, ID_reg_out_src2, ID_reg_out_dest,
      output ID_reg_out_WBEN, ID_reg_out_MEM_R, ID_reg_out_MEM_W,
      output EXE_reg_out_DEST, EXE_reg_out_WBEN,
      output MEM_reg_out_DEST, MEM_reg_out_WBEN,
      input  forward_a_select, forward_b_select, st_val_select,
      input  hazard_stall, mem_freeze, stall_cnt
   );

   modport slave (
      input  fwd_en, mem_ready, flush,
      input  ID_src1, ID_src2, ID_two_src,
      input  ID_reg_out_src1, ID_reg_out_src2, ID_reg_out_dest,
      input  ID_reg_out_WBEN, ID_reg_out_MEM_R, ID_reg_out_MEM_W,
      input  EXE_reg_out_DEST, EXE_reg_out_WBEN,
      input  MEM_reg_out_DEST, MEM_reg_out_WBEN,
      output forward_a_select, forward_b_select, st_val_select,
      output hazard_stall, mem_freeze, stall_cnt
   );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel
// Compares one consumer register address against the producers in the MEM
// and WB stages and returns the operand mux select.
//   src      : consumer register address
//   mem_dest : destination of the producer in MEM, mem_wben its write enable
//   wb_dest  : destination of the producer in WB,  wb_wben its write enable
//   sel      : FWD_MEM, FWD_WB or FWD_RF
// ----------------------------------------------------------------------------
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wben,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic              wb_wben,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   // Writes to the zero register are never real, so they are never forwarded.
   assign mem_hit = mem_wben && (mem_dest == src) && (mem_dest != REG_AW'(ZERO_REG));
   assign wb_hit  = wb_wben  && (wb_dest  == src) && (wb_dest  != REG_AW'(ZERO_REG));

   // The MEM-stage value is the younger write, so it beats the WB-stage one.
   always_comb begin
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_forward_ctrl
// EXE-stage forwarding select generation plus ID-stage RAW hazard detection
// with a counted stall sequencer and a saturating stall-cycle counter.
//   clk, rst : pipeline clock, synchronous active-high reset
//   bus      : slave side of hazard_forward_ctrl_if
//              inputs  : fwd_en, mem_ready, flush, ID/EXE/MEM stage fields
//              outputs : forward_a/b_select, st_val_select, hazard_stall,
//                        mem_freeze, stall_cnt
// ----------------------------------------------------------------------------
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic                  clk,
   input logic                  rst,
   hazard_forward_ctrl_if.slave bus
);

   state_t           state_q, state_next;
   logic [1:0]       rem_q, rem_next;
   logic [CNT_W-1:0] cnt_q, cnt_next;
   logic [1:0]       sel_a, sel_b, sel_st;
   need_t            need_1, need_2, need_max;
   logic             hazard_stall;
   logic             mem_freeze;

   function automatic logic reg_match(input logic [REG_AW-1:0] x,
                                      input logic [REG_AW-1:0] d,
                                      input logic              wb);
      return wb && (d == x) && (d != REG_AW'(ZERO_REG));
   endfunction

   // Stall cycles a source needs. With forwarding only a load in EXE hurts;
   // without it, an EXE producer needs two bubbles and a MEM producer one.
   // WB producers are fine because the register file writes before it reads.
   function automatic need_t source_need(input logic [REG_AW-1:0] s,
                                         input logic              fwd);
      need_t n;
      n = 2'd0;
      if (fwd) begin
         if (bus.ID_reg_out_MEM_R && reg_match(s, bus.ID_reg_out_dest, bus.ID_reg_out_WBEN))
            n = 2'd1;
      end else if (reg_match(s, bus.ID_reg_out_dest, bus.ID_reg_out_WBEN)) begin
         n = 2'd2;
      end else if (reg_match(s, bus.EXE_reg_out_DEST, bus.EXE_reg_out_WBEN)) begin
         n = 2'd1;
      end
      return n;
   endfunction

   fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
      .src(bus.ID_reg_out_src1),
      .mem_dest(bus.EXE_reg_out_DEST), .mem_wben(bus.EXE_reg_out_WBEN),
      .wb_dest(bus.MEM_reg_out_DEST),  .wb_wben(bus.MEM_reg_out_WBEN),
      .sel(sel_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
      .src(bus.ID_reg_out_src2),
      .mem_dest(bus.EXE_reg_out_DEST), .mem_wben(bus.EXE_reg_out_WBEN),
      .wb_dest(bus.MEM_reg_out_DEST),  .wb_wben(bus.MEM_reg_out_WBEN),
      .sel(sel_b)
   );

   // Store data comes from the register named by the store's dest field.
   fwd_sel #(.REG_AW(REG_AW)) u_sel_st (
      .src(bus.ID_reg_out_dest),
      .mem_dest(bus.EXE_reg_out_DEST), .mem_wben(bus.EXE_reg_out_WBEN),
      .wb_dest(bus.MEM_reg_out_DEST),  .wb_wben(bus.MEM_reg_out_WBEN),
      .sel(sel_st)
   );

   // For a store, operand B is the immediate path, so src2 is never forwarded.
   assign bus.forward_a_select = (bus.fwd_en && !rst) ? sel_a : FWD_RF;
   assign bus.forward_b_select = (bus.fwd_en && !rst && !bus.ID_reg_out_MEM_W) ? sel_b : FWD_RF;
   assign bus.st_val_select    = (bus.fwd_en && !rst) ? sel_st : FWD_RF;

   // Hazard depth for the ID instruction: worst case over the sources it reads.
   always_comb begin
      need_1   = source_need(bus.ID_src1, bus.fwd_en);
      need_2   = bus.ID_two_src ? source_need(bus.ID_src2, bus.fwd_en) : 2'd0;
      need_max = (need_2 > need_1) ? need_2 : need_1;
   end

   // State register, remaining-cycle counter and stall statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         rem_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_next;
         rem_q   <= rem_next;
         cnt_q   <= cnt_next;
      end
   end

   // Next state. A frozen pipeline holds everything; a flush squashes the
   // stalled instruction, so any pending stall is dropped.
   always_comb begin
      state_next = state_q;
      rem_next   = rem_q;
      if (bus.mem_ready) begin
         if (bus.flush) begin
            state_next = RUN;
            rem_next   = 2'd0;
         end else begin
            case (state_q)
               RUN: begin
                  if (need_max == 2'd2) begin
                     state_next = STALL;
                     rem_next   = 2'd1;
                  end
               end
               STALL: begin
                  if (rem_q <= 2'd1) begin
                     state_next = RUN;
                     rem_next   = 2'd0;
                  end else begin
                     rem_next = rem_q - 2'd1;
                  end
               end
               default: begin
                  state_next = RUN;
                  rem_next   = 2'd0;
               end
            endcase
         end
      end
      cnt_next = (hazard_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // Outputs. The hazard is only looked at in RUN; STALL just finishes the count.
   always_comb begin
      hazard_stall = 1'b0;
      mem_freeze   = 1'b0;
      if (!rst) begin
         mem_freeze = !bus.mem_ready;
         if (bus.mem_ready && !bus.flush) begin
            case (state_q)
               RUN:     hazard_stall = (need_max != 2'd0);
               STALL:   hazard_stall = 1'b1;
               default: hazard_stall = 1'b0;
            endcase
         end
      end
   end

   assign bus.hazard_stall = hazard_stall;
   assign bus.mem_freeze   = mem_freeze;
   assign bus.stall_cnt    = rst ? '0 : cnt_q;

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised successor to the pipeline forwarding unit: combines EXE-stage operand forwarding select generation with ID-stage RAW hazard detection and a counted stall state machine. A mode input switches between forwarding operation (only load-use stalls) and no-forwarding operation (full RAW stalls). The block also freezes the pipeline on memory back-pressure, aborts stalls on branch flush, and keeps a saturating stall-cycle counter. It sits between the ID/EXE/MEM pipeline registers and the PC/IF-ID/ID-EX register controls.

## Interface
- REG_AW, 5: register address width; address 0 is the hardwired zero register.
- CNT_W, 16: width of the stall statistics counter.
- clk  in  1  pipeline clock.
- rst  in  1  reset. Synchronous, active-high; one clock only.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- mem_ready  in  1  memory stage ready; 0 freezes the whole pipeline.
- flush  in  1  branch taken in EXE; the ID instruction is squashed.
- ID_src1, ID_src2  in  REG_AW  source registers of the instruction in ID.
- ID_two_src  in  1  ID instruction reads ID_src2 (R-type or store).
- ID_reg_out_src1, ID_reg_out_src2, ID_reg_out_dest  in  REG_AW  operands of the instruction in EXE.
- ID_reg_out_WBEN, ID_reg_out_MEM_R, ID_reg_out_MEM_W  in  1  controls of the instruction in EXE.
- EXE_reg_out_DEST  in  REG_AW,  EXE_reg_out_WBEN  in  1  producer in MEM.
- MEM_reg_out_DEST  in  REG_AW,  MEM_reg_out_WBEN  in  1  producer in WB.
- forward_a_select, forward_b_select, st_val_select  out  2  mux selects: 00 register file, 01 MEM-stage result, 10 WB-stage result.
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- mem_freeze  out  1  hold all pipeline registers.
- stall_cnt  out  CNT_W  count of hazard_stall cycles.

## Operation
- Match(x, d, wb) = wb && d == x && d != 0.
- forward_a_select: 01 if Match(ID_reg_out_src1, EXE_reg_out_DEST, EXE_reg_out_WBEN). Otherwise 10 if Match with MEM_reg_out. Otherwise 00. The MEM stage always has priority.
- forward_b_select: same rule on ID_reg_out_src2, and forced to 00 when ID_reg_out_MEM_W=1.
- st_val_select: same rule on ID_reg_out_dest (store data register), with the same MEM-over-WB priority.
- All three selects are 00 when fwd_en=0 or rst=1.
- Hazard condition for each ID source s it uses (src1 always; src2 only if ID_two_src):
  - fwd_en=1: ID_reg_out_MEM_R && Match(s, ID_reg_out_dest, ID_reg_out_WBEN) requires N=1.
  - fwd_en=0: Match with ID_reg_out_* requires N=2. Otherwise, Match with EXE_reg_out_* requires N=1.
  - Take the maximum N over both sources.
  - A WB-stage producer never stalls, because the register file is write-before-read.
- FSM states are RUN and STALL. There is a remaining-cycle counter rem of width 2.
  - RUN, hazard with N≥1: hazard_stall=1 this cycle. If N=2, go to STALL with rem=1. Otherwise stay in RUN.
  - STALL: hazard_stall=1. Decrement rem. Return to RUN when rem reaches 0. The hazard is not re-evaluated in STALL.
  - fwd_en is only sampled in RUN.
- flush=1: hazard_stall=0 in that cycle and the next state is RUN with rem=0. Flush wins over a simultaneous hazard.
- mem_ready=0: mem_freeze=1 and hazard_stall=0. The state, rem and stall_cnt hold. Evaluation resumes on the first cycle with mem_ready=1.
- stall_cnt increments on every cycle with hazard_stall=1 and saturates at all-ones.

## Timing
- Selects, hazard_stall and mem_freeze are combinational from inputs and state, with zero latency.
- stall_cnt, state and rem are registered and update on the rising edge of clk.
- While rst=1: state=RUN, rem=0, stall_cnt=0, and all outputs are 0 (mem_freeze included).
- rst asserted mid-STALL: returns to RUN on that edge; no residual stall.
- Load-use in forwarding mode: exactly 1 stall cycle.
- No-forwarding mode: 2 cycles for an EXE-stage producer, 1 cycle for a MEM-stage producer.
- stall_cnt reflects a stall cycle on the edge that ends it.

## Structure
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - State enum {RUN, STALL}.
  - Function or constant for the zero-register index.
- Sub-module fwd_sel (one source address against two producers, returns the 2-bit select). Instantiated three times.

## Test plan
- fwd_en=1, EXE_reg_out_DEST=3 WBEN=1, MEM_reg_out_DEST=3 WBEN=1, ID_reg_out_src1=3 -> forward_a_select=01. Same case with EXE_reg_out_DEST=0 -> 10.
- Store with ID_reg_out_MEM_W=1, ID_reg_out_src2=ID_reg_out_dest=5, EXE_reg_out_DEST=5 -> forward_b_select=00, st_val_select=01.
- fwd_en=1, load to r7 in EXE, ID_src1=7 -> hazard_stall high for exactly 1 cycle, stall_cnt 0→1.
- fwd_en=0, ALU write to r4 in EXE, ID_two_src=1, ID_src2=4 -> hazard_stall for 2 cycles, stall_cnt=2. mem_ready=0 during cycle 2 -> stall holds and resumes for 1 more cycle after mem_ready returns high.
- fwd_en=0, 2-cycle stall with flush=1 in its second cycle -> hazard_stall=0 that cycle and state=RUN. rst mid-STALL -> all outputs 0, stall_cnt=0.
- CNT_W=2, four consecutive single-cycle stalls -> stall_cnt saturates at 3.
